// File: rtl/parity_demux_pkg.sv
// Shared mode encodings and lane state type for the parity demultiplexer.
package parity_demux_pkg;

  localparam logic MODE_XOR  = 1'b0;
  localparam logic MODE_XNOR = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } lane_state_t;

endpackage

// File: rtl/parity_demux_lane.sv
// One demux lane: folds a frame with XOR, applies the XNOR inversion latched
// on the first beat, and holds the result under a valid/ready handshake.
module parity_demux_lane
  import parity_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             accept,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_mode,
  input  logic             in_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_word,
  output logic             out_par
);

  lane_state_t      state;
  lane_state_t      state_next;
  logic [WIDTH-1:0] acc;
  logic             mode;
  logic [WIDTH-1:0] fold;
  logic             eff_mode;

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (accept) state_next = in_last ? ST_IDLE : ST_ACCUM;
  end

  // A single-beat frame must use the mode of that same beat, not the stale latch.
  always_comb begin
    fold     = acc ^ in_data;
    eff_mode = (state == ST_IDLE) ? in_mode : mode;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      mode      <= MODE_XOR;
      out_valid <= 1'b0;
      out_word  <= '0;
      out_par   <= 1'b0;
    end else if (accept) begin
      if (state == ST_IDLE) mode <= in_mode;
      if (in_last) begin
        out_word  <= fold ^ {WIDTH{eff_mode}};
        out_par   <= (^fold) ^ eff_mode;
        out_valid <= 1'b1;
        acc       <= '0;
      end else begin
        acc <= fold;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/parity_demux.sv
// Routes beats to CHANNELS independent parity lanes; flags out-of-range selects.
module parity_demux
  import parity_demux_pkg::*;
#(
  parameter  int WIDTH    = 8,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic                      in_mode,
  input  logic                      in_last,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_word,
  output logic [CHANNELS-1:0]       out_par,
  output logic                      err_sel
);

  logic sel_ok;
  logic lane_busy;

  // Range check is constant-true for power-of-2 CHANNELS.
  always_comb begin
    sel_ok    = ({1'b0, in_sel} < (SEL_W + 1)'(CHANNELS));
    lane_busy = 1'b0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (in_sel == SEL_W'(i)) lane_busy = out_valid[i];
    end
    in_ready = sel_ok ? ~lane_busy : 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_sel <= 1'b0;
    else     err_sel <= in_valid && !sel_ok;
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
    parity_demux_lane #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .accept   (in_valid && in_ready && sel_ok && (in_sel == SEL_W'(g))),
      .in_data  (in_data),
      .in_mode  (in_mode),
      .in_last  (in_last),
      .out_ready(out_ready[g]),
      .out_valid(out_valid[g]),
      .out_word (out_word[g*WIDTH +: WIDTH]),
      .out_par  (out_par[g])
    );
  end

endmodule

// File: tb/tb_parity_demux.sv
// Scoreboard bench for parity_demux: 4-lane instance plus a 3-lane instance
// for out-of-range select handling.
module tb_parity_demux;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_mode, in_last;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid, out_ready, out_par;
  logic [31:0] out_word;
  logic        err_sel;

  logic        in_valid3, in_ready3, in_mode3, in_last3;
  logic [7:0]  in_data3;
  logic [1:0]  in_sel3;
  logic [2:0]  out_valid3, out_ready3, out_par3;
  logic [23:0] out_word3;
  logic        err_sel3;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] word;
    logic       par;
  } exp_t;
  exp_t       sb_q[$];
  logic [3:0] seen;

  always #5 clk = ~clk;

  parity_demux #(.WIDTH(8), .CHANNELS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .in_mode(in_mode), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_par(out_par), .err_sel(err_sel)
  );

  parity_demux #(.WIDTH(8), .CHANNELS(3)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_sel(in_sel3), .in_mode(in_mode3), .in_last(in_last3),
    .out_valid(out_valid3), .out_ready(out_ready3), .out_word(out_word3),
    .out_par(out_par3), .err_sel(err_sel3)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic expect_result(input int lane, input logic [7:0] word, input logic par);
    exp_t e;
    e.lane = lane[1:0];
    e.word = word;
    e.par  = par;
    sb_q.push_back(e);
  endtask

  // Called just after a falling edge; returns just after the falling edge following acceptance.
  task automatic send(input int lane, input logic [7:0] d, input logic m, input logic l);
    int n = 0;
    in_sel   = lane[1:0];
    in_data  = d;
    in_mode  = m;
    in_last  = l;
    in_valid = 1'b1;
    #1;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check("ready_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    if (l) check($sformatf("lat_valid%0d", lane), {31'd0, out_valid[lane]}, 32'd1);
  endtask

  always @(negedge clk) begin : monitor
    int idx;
    if (rst) begin
      seen = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && !seen[i]) begin
          idx = -1;
          for (int j = 0; j < sb_q.size(); j++)
            if (idx < 0 && sb_q[j].lane == i[1:0]) idx = j;
          if (idx < 0) begin
            check($sformatf("unexpected_result%0d", i), 32'd1, 32'd0);
          end else begin
            check($sformatf("word%0d", i), {24'd0, out_word[i*8 +: 8]}, {24'd0, sb_q[idx].word});
            check($sformatf("par%0d", i), {31'd0, out_par[i]}, {31'd0, sb_q[idx].par});
            sb_q.delete(idx);
          end
        end
        seen[i] = out_valid[i];
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_sel = '0; in_mode = 1'b0; in_last = 1'b0;
    out_ready = '1;
    in_valid3 = 1'b0; in_data3 = '0; in_sel3 = '0; in_mode3 = 1'b0; in_last3 = 1'b0;
    out_ready3 = '1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_valid", {28'd0, out_valid}, 32'd0);
    check("rst_word",  out_word, 32'd0);
    check("rst_par",   {28'd0, out_par}, 32'd0);
    check("rst_err",   {31'd0, err_sel}, 32'd0);
    check("rst_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // single-beat frames, XOR then XNOR
    expect_result(0, 8'hA5, 1'b0);
    send(0, 8'hA5, 1'b0, 1'b1);
    expect_result(0, 8'h5A, 1'b1);
    send(0, 8'hA5, 1'b1, 1'b1);

    // multi-beat XNOR frame; mode changes on later beats are ignored
    expect_result(2, 8'h01, 1'b0);
    send(2, 8'h0F, 1'b1, 1'b0);
    send(2, 8'hF0, 1'b0, 1'b0);
    send(2, 8'h01, 1'b1, 1'b1);

    // backpressure: pending lane 1 stalls only beats addressed to lane 1
    out_ready[1] = 1'b0;
    expect_result(1, 8'h07, 1'b1);
    send(1, 8'h07, 1'b0, 1'b1);
    in_sel = 2'd1;
    #1 check("ready_busy", {31'd0, in_ready}, 32'd0);
    in_sel = 2'd3;
    #1 check("ready_other", {31'd0, in_ready}, 32'd1);
    repeat (3) @(negedge clk);
    check("hold_valid1", {31'd0, out_valid[1]}, 32'd1);
    out_ready[1] = 1'b1;
    @(negedge clk);
    out_ready[1] = 1'b0;
    check("drop_valid1", {31'd0, out_valid[1]}, 32'd0);
    in_sel = 2'd1;
    #1 check("ready_freed", {31'd0, in_ready}, 32'd1);
    out_ready[1] = 1'b1;

    // interleaved frames on lanes 0 and 3
    expect_result(0, 8'h33, 1'b0);
    expect_result(3, 8'h81, 1'b0);
    send(0, 8'h11, 1'b0, 1'b0);
    send(3, 8'h80, 1'b0, 1'b0);
    send(0, 8'h22, 1'b0, 1'b1);
    send(3, 8'h01, 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    check("hold_word0", {24'd0, out_word[7:0]}, 32'h33);

    // reset mid-frame discards the partial accumulation
    send(1, 8'hFF, 1'b0, 1'b0);
    send(1, 8'h0F, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst2_word", out_word, 32'd0);
    check("rst2_valid", {28'd0, out_valid}, 32'd0);
    expect_result(1, 8'h3C, 1'b0);
    send(1, 8'h3C, 1'b0, 1'b1);

    n = 0;
    while (sb_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("sb_empty", sb_q.size(), 32'd0);

    // 3-lane instance: out-of-range select dropped with one-cycle err_sel
    in_sel3 = 2'd3; in_data3 = 8'hFF; in_last3 = 1'b1; in_mode3 = 1'b0; in_valid3 = 1'b1;
    #1 check("ready_oor", {31'd0, in_ready3}, 32'd1);
    @(negedge clk);
    in_valid3 = 1'b0;
    check("err_pulse", {31'd0, err_sel3}, 32'd1);
    check("oor_valid", {29'd0, out_valid3}, 32'd0);
    @(negedge clk);
    check("err_clear", {31'd0, err_sel3}, 32'd0);
    check("oor_valid2", {29'd0, out_valid3}, 32'd0);
    in_sel3 = 2'd2; in_data3 = 8'h81; in_mode3 = 1'b1; in_valid3 = 1'b1;
    @(negedge clk);
    in_valid3 = 1'b0;
    check("c3_valid", {29'd0, out_valid3}, 32'h4);
    check("c3_word", {24'd0, out_word3[23:16]}, 32'h7E);
    check("c3_par", {31'd0, out_par3[2]}, 32'd1);
    check("c3_err", {31'd0, err_sel3}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
